instr_mem_loader: RTL and testbench

- Boot-time controller for the instruction memory.
- Accepts a little-endian byte stream (valid/ready), assembles 32-bit words and sequences word writes into the instruction memory's single address/load/in port.
- Muxes that port between itself (while loading) and the CPU fetch path (after loading). Holds the CPU stalled until the image is complete.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/instr_mem_loader_byte_assembler.sv | 39 +++
 rtl/instr_mem_loader.sv | 162 ++++++++++++++++
 tb/tb_instr_mem_loader.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   state_t : loader FSM encoding
//   NOP     : instruction presented to the CPU while it is stalled (addi x0,x0,0)
package riscv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        WRITE,
        CHK,
        DONE,
        ERR
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/instr_mem_loader_byte_assembler.sv
// byte_assembler: packs a little-endian byte stream into 32-bit words.
//   clk, rst_n  : clock, async active-low reset
//   clr         : synchronous clear of byte counter and shift register
//   en          : a byte is accepted this cycle
//   din         : the byte
//   word_valid  : combinational pulse, high on the cycle the 4th byte is accepted
//   word        : assembled word (valid with word_valid); first byte in [7:0]
module byte_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  din,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  cnt;
    // Only three bytes ever need to be held: the fourth comes straight from din,
    // so the word is available in the same cycle it completes.
    logic [23:0] sr;

    assign word       = {din, sr};
    assign word_valid = en && (cnt == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sr  <= '0;
        end else if (clr) begin
            cnt <= '0;
            sr  <= '0;
        end else if (en) begin
            cnt <= cnt + 2'd1;          // wraps 3 -> 0 at each word boundary
            sr  <= word[31:8];
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: boot-time loader for the instruction memory.
// Receives a byte stream (4-byte LE word count N, then N LE words), writes the
// words to addresses 0..N-1 through the memory's single port, then hands the
// port to the CPU fetch path and releases the stall.
// Optional: define INSTR_MEM_LOADER_CHECKSUM_EN to require a trailing 4-byte
// word equal to the mod-2^32 sum of all data words.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start                      pulse: (re)load an image (ignored while busy)
//   byte_valid/byte_data/byte_ready   stream input handshake
//   cpu_adr / cpu_instr / cpu_stall   CPU fetch side
//   mem_adr / mem_load / mem_in / mem_out   memory port (combinational read)
//   busy, done, error          status; error is sticky until start or reset
module instr_mem_loader
    import riscv_pkg::*;
#(
    parameter int MEM_SIZE = 1024,
    parameter int ADR_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    input  logic [ADR_W-1:0] cpu_adr,
    output logic [31:0]      cpu_instr,
    output logic             cpu_stall,
    output logic [ADR_W-1:0] mem_adr,
    output logic             mem_load,
    output logic [31:0]      mem_in,
    input  logic [31:0]      mem_out,
    output logic             busy,
    output logic             done,
    output logic             error
);

    // One extra bit so a count of exactly MEM_SIZE fits without wrapping.
    localparam int CNT_W = $clog2(MEM_SIZE) + 1;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wcnt, nwords, wcnt_inc;
    logic [31:0]      wdata;
    logic             accept, restart;
    logic             asm_vld;
    logic [31:0]      asm_word;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    logic [31:0]      sum;
`endif

    assign accept   = byte_valid && byte_ready;
    assign restart  = start && (state == IDLE || state == DONE || state == ERR);
    assign wcnt_inc = wcnt + CNT_W'(1);

    byte_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (restart),
        .en         (accept),
        .din        (byte_data),
        .word_valid (asm_vld),
        .word       (asm_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        byte_ready = 1'b0;
        mem_load   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        cpu_stall  = 1'b1;
        cpu_instr  = NOP;
        mem_adr    = ADR_W'(wcnt);
        mem_in     = wdata;
        case (state)
            IDLE: begin
                if (start) state_nxt = HDR;
            end
            HDR: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (asm_vld) begin
                    if (asm_word == 32'd0)                state_nxt = DONE;
                    else if (asm_word > 32'(MEM_SIZE))    state_nxt = ERR;
                    else                                  state_nxt = DATA;
                end
            end
            DATA: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (asm_vld) state_nxt = WRITE;
            end
            WRITE: begin
                busy     = 1'b1;
                mem_load = 1'b1;
                if (wcnt_inc == nwords) begin
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
                    state_nxt = CHK;
`else
                    state_nxt = DONE;
`endif
                end else begin
                    state_nxt = DATA;
                end
            end
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
            CHK: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (asm_vld) state_nxt = (asm_word == sum) ? DONE : ERR;
            end
`endif
            DONE: begin
                done      = 1'b1;
                cpu_stall = 1'b0;
                mem_adr   = cpu_adr;
                cpu_instr = mem_out;
                if (start) state_nxt = HDR;
            end
            ERR: begin
                error = 1'b1;
                if (start) state_nxt = HDR;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt   <= '0;
            nwords <= '0;
            wdata  <= '0;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
            sum    <= '0;
`endif
        end else begin
            if (restart) begin
                wcnt <= '0;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
                sum  <= '0;
`endif
            end
            // Only counts already range-checked against MEM_SIZE reach DATA,
            // so the truncated value is exact whenever it is used.
            if (state == HDR && asm_vld) nwords <= asm_word[CNT_W-1:0];
            if (state == DATA && asm_vld) wdata <= asm_word;
            if (state == WRITE) begin
                wcnt <= wcnt_inc;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
                sum  <= sum + wdata;
`endif
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

    localparam int ADR_W = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             byte_valid = 1'b0;
    logic [7:0]       byte_data = '0;
    logic             byte_ready;
    logic [ADR_W-1:0] cpu_adr = '0;
    logic [31:0]      cpu_instr;
    logic             cpu_stall;
    logic [ADR_W-1:0] mem_adr;
    logic             mem_load;
    logic [31:0]      mem_in;
    logic [31:0]      mem_out;
    logic             busy, done, error;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instr_mem_loader #(.MEM_SIZE(1024), .ADR_W(ADR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .cpu_adr    (cpu_adr),
        .cpu_instr  (cpu_instr),
        .cpu_stall  (cpu_stall),
        .mem_adr    (mem_adr),
        .mem_load   (mem_load),
        .mem_in     (mem_in),
        .mem_out    (mem_out),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    // Instruction memory with combinational read, plus a log of every write.
    logic [31:0] mem [0:1023];
    logic [31:0] la [0:63];
    logic [31:0] ld [0:63];
    int          nload = 0;

    assign mem_out = mem[mem_adr[9:0]];

    always @(posedge clk) begin
        if (mem_load) begin
            mem[mem_adr[9:0]] <= mem_in;
            la[nload[5:0]]    <= mem_adr;
            ld[nload[5:0]]    <= mem_in;
            nload             <= nload + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        waited     = 0;
        while (!byte_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!byte_ready) begin
            chk("byte_ready_timeout", {31'd0, byte_ready}, 32'd1);
            byte_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 byte_valid = 1'b0;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit rnd);
        send_byte(w[7:0],   rnd ? int'($urandom_range(0, 2)) : 0);
        send_byte(w[15:8],  rnd ? int'($urandom_range(0, 2)) : 0);
        send_byte(w[23:16], rnd ? int'($urandom_range(0, 2)) : 0);
        send_byte(w[31:24], rnd ? int'($urandom_range(0, 2)) : 0);
    endtask

    // Trailer only exists when the checksum option is built in.
    task automatic send_trailer(input logic [31:0] w);
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
        send_word(w, 1'b0);
`else
        if (w == 32'hFFFF_FFFF) $display("unused trailer");
`endif
    endtask

    task automatic wait_end();
        int k;
        k = 0;
        while (!(done || error) && k < 30) begin
            @(negedge clk);
            k++;
        end
        if (!(done || error)) chk("end_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, {31'd0, byte_ready}, 32'd0);
        chk({tag, "_load"},  {31'd0, mem_load},   32'd0);
        chk({tag, "_busy"},  {31'd0, busy},       32'd0);
        chk({tag, "_done"},  {31'd0, done},       32'd0);
        chk({tag, "_error"}, {31'd0, error},      32'd0);
        chk({tag, "_stall"}, {31'd0, cpu_stall},  32'd1);
        chk({tag, "_instr"}, cpu_instr,           32'h0000_0013);
    endtask

    initial begin
        int base;

        // --- reset state
        #12;
        chk_reset_outputs("rst");
        chk("rst_adr", mem_adr, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // --- N=2: DEADBEEF, 00000013
        base = nload;
        pulse_start();
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_ready", {31'd0, byte_ready}, 32'd1);
        send_word(32'd2, 1'b0);
        send_word(32'hDEAD_BEEF, 1'b0);
        send_word(32'h0000_0013, 1'b0);
        send_trailer(32'hDEAD_BF02);
        wait_end();
        chk("t1_nload", nload - base, 32'd2);
        chk("t1_adr0", la[base], 32'd0);
        chk("t1_dat0", ld[base], 32'hDEAD_BEEF);
        chk("t1_adr1", la[base+1], 32'd1);
        chk("t1_dat1", ld[base+1], 32'h0000_0013);
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_stall", {31'd0, cpu_stall}, 32'd0);
        chk("t1_busy_lo", {31'd0, busy}, 32'd0);
        cpu_adr = 32'd0; #1;
        chk("t1_fetch0", cpu_instr, 32'hDEAD_BEEF);
        chk("t1_madr", mem_adr, 32'd0);
        cpu_adr = 32'd1; #1;
        chk("t1_fetch1", cpu_instr, 32'h0000_0013);
        chk("t1_madr1", mem_adr, 32'd1);

        // --- N=0: straight to DONE, no writes
        base = nload;
        pulse_start();
        chk("t2_done_lo", {31'd0, done}, 32'd0);
        chk("t2_stall_hi", {31'd0, cpu_stall}, 32'd1);
        send_word(32'd0, 1'b0);
        wait_end();
        chk("t2_nload", nload - base, 32'd0);
        chk("t2_done", {31'd0, done}, 32'd1);
        chk("t2_stall", {31'd0, cpu_stall}, 32'd0);

        // --- N=MEM_SIZE+1: rejected
        base = nload;
        pulse_start();
        send_word(32'd1025, 1'b0);
        wait_end();
        chk("t3_error", {31'd0, error}, 32'd1);
        chk("t3_done", {31'd0, done}, 32'd0);
        chk("t3_stall", {31'd0, cpu_stall}, 32'd1);
        chk("t3_instr", cpu_instr, 32'h0000_0013);
        chk("t3_busy", {31'd0, busy}, 32'd0);
        chk("t3_ready", {31'd0, byte_ready}, 32'd0);
        chk("t3_nload", nload - base, 32'd0);
        repeat (3) @(negedge clk);
        chk("t3_sticky", {31'd0, error}, 32'd1);

        // --- N=3 with random gaps; start pulsed mid-load must be ignored
        base = nload;
        pulse_start();
        chk("t4_err_clr", {31'd0, error}, 32'd0);
        send_word(32'd3, 1'b1);
        pulse_start();
        send_word(32'h1122_3344, 1'b1);
        send_word(32'hA5A5_0F0F, 1'b1);
        pulse_start();
        send_word(32'h0000_0001, 1'b1);
        send_trailer(32'hB6C7_4254);
        wait_end();
        chk("t4_nload", nload - base, 32'd3);
        chk("t4_adr0", la[base], 32'd0);
        chk("t4_dat0", ld[base], 32'h1122_3344);
        chk("t4_adr1", la[base+1], 32'd1);
        chk("t4_dat1", ld[base+1], 32'hA5A5_0F0F);
        chk("t4_adr2", la[base+2], 32'd2);
        chk("t4_dat2", ld[base+2], 32'h0000_0001);
        chk("t4_done", {31'd0, done}, 32'd1);
        cpu_adr = 32'd2; #1;
        chk("t4_fetch2", cpu_instr, 32'h0000_0001);

        // --- reset after 6 data bytes, then reload N=1
        base = nload;
        pulse_start();
        send_word(32'd2, 1'b0);
        send_word(32'hCAFE_F00D, 1'b0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        @(negedge clk);
        chk("t5_nload_mid", nload - base, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("t5_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base = nload;
        pulse_start();
        send_word(32'd1, 1'b0);
        send_word(32'h1234_5678, 1'b0);
        send_trailer(32'h1234_5678);
        wait_end();
        chk("t5_nload", nload - base, 32'd1);
        chk("t5_adr0", la[base], 32'd0);
        chk("t5_dat0", ld[base], 32'h1234_5678);
        chk("t5_done", {31'd0, done}, 32'd1);
        cpu_adr = 32'd0; #1;
        chk("t5_fetch0", cpu_instr, 32'h1234_5678);

`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
        // --- checksum: words 1,2 with good (3) and bad (4) trailer
        pulse_start();
        send_word(32'd2, 1'b0);
        send_word(32'd1, 1'b0);
        send_word(32'd2, 1'b0);
        send_word(32'd3, 1'b0);
        wait_end();
        chk("t6_done", {31'd0, done}, 32'd1);
        chk("t6_error", {31'd0, error}, 32'd0);
        pulse_start();
        send_word(32'd2, 1'b0);
        send_word(32'd1, 1'b0);
        send_word(32'd2, 1'b0);
        send_word(32'd4, 1'b0);
        wait_end();
        chk("t7_error", {31'd0, error}, 32'd1);
        chk("t7_done", {31'd0, done}, 32'd0);
        chk("t7_stall", {31'd0, cpu_stall}, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
